// File: rtl/occupancy_gate_ctrl.sv
// Gate sequencer: turns two beam-sensor passes into counter up/down pulses.
// Entry is A->AB->B->none, exit is the mirror; aborted passes emit nothing.
module occupancy_gate_ctrl #(
  parameter int CW        = 4,
  parameter int MAX_COUNT = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sensor_a,
  input  logic          sensor_b,
  input  logic [CW-1:0] count,
  output logic          up,
  output logic          down,
  output logic          reject,
  output logic          underflow,
  output logic          full,
  output logic          empty,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3
  } state_t;

  state_t state, nxt;
  logic   a_p0, a_p1, b_p0, b_p1;
  logic   sa, sb;
  logic   entry_done, exit_done;

  assign sa    = a_p1;
  assign sb    = b_p1;
  assign full  = (count >= CW'(MAX_COUNT));
  assign empty = (count == '0);

  always_comb begin
    nxt        = state;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sa && !sb)      nxt = EN1;
        else if (!sa && sb) nxt = EX1;
      end
      EN1: begin
        if (sa && sb)       nxt = EN2;
        else if (!sa)       nxt = IDLE;
      end
      EN2: begin
        if (!sa && sb)      nxt = EN3;
        else if (sa && !sb) nxt = EN1;
        else if (!sa && !sb) nxt = IDLE;
      end
      EN3: begin
        if (!sa && !sb) begin
          nxt        = IDLE;
          entry_done = 1'b1;
        end
        else if (sa && sb)  nxt = EN2;
        else if (sa)        nxt = IDLE;
      end
      EX1: begin
        if (sa && sb)       nxt = EX2;
        else if (!sb)       nxt = IDLE;
      end
      EX2: begin
        if (sa && !sb)      nxt = EX3;
        else if (!sa && sb) nxt = EX1;
        else if (!sa && !sb) nxt = IDLE;
      end
      EX3: begin
        if (!sa && !sb) begin
          nxt       = IDLE;
          exit_done = 1'b1;
        end
        else if (sa && sb)  nxt = EX2;
        else if (sb)        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // stage p0/p1: two-flop synchronizers; FSM stage registers state and pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0      <= 1'b0;
      a_p1      <= 1'b0;
      b_p0      <= 1'b0;
      b_p1      <= 1'b0;
      state     <= IDLE;
      up        <= 1'b0;
      down      <= 1'b0;
      reject    <= 1'b0;
      underflow <= 1'b0;
      busy      <= 1'b0;
    end else begin
      a_p0      <= sensor_a;
      a_p1      <= a_p0;
      b_p0      <= sensor_b;
      b_p1      <= b_p0;
      state     <= nxt;
      busy      <= (nxt != IDLE);
      up        <= entry_done && !full;
      reject    <= entry_done && full;
      down      <= exit_done && !empty;
      underflow <= exit_done && empty;
    end
  end

endmodule

// File: tb/tb_occupancy_gate_ctrl.sv
// Directed bench for occupancy_gate_ctrl: entry/exit passes, full/empty limits,
// aborted sequences and reset mid-pass.
module tb_occupancy_gate_ctrl;

  localparam int CW = 4;
  localparam int MAX_COUNT = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          sensor_a, sensor_b;
  logic [CW-1:0] count;
  logic          up, down, reject, underflow, full, empty, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_up = 0, n_down = 0, n_rej = 0, n_und = 0, n_both = 0;

  occupancy_gate_ctrl #(.CW(CW), .MAX_COUNT(MAX_COUNT)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .count(count), .up(up), .down(down), .reject(reject),
    .underflow(underflow), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (up)        n_up++;
    if (down)      n_down++;
    if (reject)    n_rej++;
    if (underflow) n_und++;
    if (up && down) n_both++;
  end

  // called at a negedge; returns at a negedge
  task automatic drive(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic entry_pass();
    drive(1, 0, 4); drive(1, 1, 4); drive(0, 1, 4); drive(0, 0, 8);
  endtask

  task automatic exit_pass();
    drive(0, 1, 4); drive(1, 1, 4); drive(1, 0, 4); drive(0, 0, 8);
  endtask

  task automatic test_reset();
    reset = 1'b1; sensor_a = 0; sensor_b = 0; count = 4'd3;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({up, down, reject, underflow, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {up, down, reject, underflow, busy});
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({up, down, reject, underflow, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want 00000", {up, down, reject, underflow, busy});
    end
    n_checks++;
    if ({full, empty} !== 2'b00) begin
      n_fail++;
      $display("FAIL flags_count3: got %b want 00", {full, empty});
    end
  endtask

  task automatic test_entry();
    int u0, o0;
    count = 4'd3;
    u0 = n_up; o0 = n_down + n_rej + n_und;
    drive(1, 0, 4); drive(1, 1, 4); drive(0, 1, 4);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL entry_busy: got %b want 1", busy);
    end
    sensor_a = 0; sensor_b = 0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (up !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_early_up: got %b want 0", up);
    end
    @(posedge clk); #1;
    n_checks++;
    if (up !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_up_latency: got up=%b busy=%b want up=1 busy=0", up, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (up !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_up_width: got %b want 0", up);
    end
    @(negedge clk);
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_up - u0 !== 1 || n_down + n_rej + n_und - o0 !== 0) begin
      n_fail++;
      $display("FAIL entry_counts: got up=%0d other=%0d want 1 0", n_up - u0, n_down + n_rej + n_und - o0);
    end
  endtask

  task automatic test_exit();
    int d0, o0;
    count = 4'd5;
    d0 = n_down; o0 = n_up + n_rej + n_und;
    exit_pass();
    n_checks++;
    if (n_down - d0 !== 1 || n_up + n_rej + n_und - o0 !== 0) begin
      n_fail++;
      $display("FAIL exit_counts: got down=%0d other=%0d want 1 0", n_down - d0, n_up + n_rej + n_und - o0);
    end
  endtask

  task automatic test_full();
    int r0, u0;
    count = 4'd10;
    @(negedge clk);
    n_checks++;
    if ({full, empty} !== 2'b10) begin
      n_fail++;
      $display("FAIL flags_full: got %b want 10", {full, empty});
    end
    r0 = n_rej; u0 = n_up;
    entry_pass();
    n_checks++;
    if (n_rej - r0 !== 1 || n_up - u0 !== 0) begin
      n_fail++;
      $display("FAIL full_reject: got reject=%0d up=%0d want 1 0", n_rej - r0, n_up - u0);
    end
  endtask

  task automatic test_empty();
    int f0, d0;
    count = 4'd0;
    @(negedge clk);
    n_checks++;
    if ({full, empty} !== 2'b01) begin
      n_fail++;
      $display("FAIL flags_empty: got %b want 01", {full, empty});
    end
    f0 = n_und; d0 = n_down;
    exit_pass();
    n_checks++;
    if (n_und - f0 !== 1 || n_down - d0 !== 0) begin
      n_fail++;
      $display("FAIL empty_underflow: got underflow=%0d down=%0d want 1 0", n_und - f0, n_down - d0);
    end
  endtask

  task automatic test_aborts();
    int t0;
    count = 4'd5;
    t0 = n_up + n_down + n_rej + n_und;
    drive(1, 0, 4);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: got %b want 1", busy);
    end
    drive(0, 0, 8);
    drive(1, 0, 4); drive(1, 1, 4); drive(1, 0, 4); drive(0, 0, 8);
    drive(0, 1, 4); drive(1, 1, 4); drive(0, 1, 4); drive(0, 0, 8);
    // loitering EN2<->EN3 then backing out
    drive(1, 0, 4); drive(1, 1, 4); drive(0, 1, 4); drive(1, 1, 4);
    drive(0, 1, 4); drive(1, 1, 4); drive(1, 0, 4); drive(0, 0, 8);
    n_checks++;
    if (n_up + n_down + n_rej + n_und - t0 !== 0) begin
      n_fail++;
      $display("FAIL abort_pulses: got %0d want 0", n_up + n_down + n_rej + n_und - t0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int u0;
    count = 4'd3;
    u0 = n_up;
    drive(1, 0, 4); drive(1, 1, 4); drive(0, 1, 4);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL en3_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || up !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b up=%b want 0 0", busy, up);
    end
    @(negedge clk);
    drive(0, 0, 3);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (n_up - u0 !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got up=%0d busy=%b want 0 0", n_up - u0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int u0;
    count = 4'd3;
    u0 = n_up;
    entry_pass();
    count = 4'd4;
    entry_pass();
    n_checks++;
    if (n_up - u0 !== 2) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d want 2", n_up - u0);
    end
    n_checks++;
    if (n_both !== 0) begin
      n_fail++;
      $display("FAIL up_down_overlap: got %0d want 0", n_both);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_entry();
    test_exit();
    test_full();
    test_empty();
    test_aborts();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
